// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcode encoding, sequencer states and opcode
// classification helpers used by the memory sequencer and the core.
package mu0_pkg;

   localparam int OPCODE_W = 4;
   localparam int IMM_W    = 12;

   typedef enum logic [OPCODE_W-1:0] {
      OP_LDA = 4'h0,
      OP_STO = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_JMP = 4'h4,
      OP_JGE = 4'h5,
      OP_JNE = 4'h6,
      OP_STP = 4'h7
   } opcode_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DATA_RD,
      S_DATA_WR,
      S_EXEC,
      S_ERROR
   } seq_state_t;

   function automatic logic opcode_needs_read(opcode_t op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

   function automatic logic opcode_needs_write(opcode_t op);
      return (op == OP_STO);
   endfunction

endpackage

// File: rtl/mu0_shared_mem_sequencer_if.sv
// Single-ported memory bus with waitrequest stall; the sequencer is master.
interface mu0_shared_mem_sequencer_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_read;
   logic                  mem_write;
   logic [DATA_WIDTH-1:0] mem_writedata;
   logic [DATA_WIDTH-1:0] mem_readdata;
   logic                  mem_waitrequest;

   modport master (
      output mem_address, mem_read, mem_write, mem_writedata,
      input  mem_readdata, mem_waitrequest
   );

   modport slave (
      input  mem_address, mem_read, mem_write, mem_writedata,
      output mem_readdata, mem_waitrequest
   );
endinterface

// File: rtl/mu0_wait_timer.sv
// Bounded-wait counter: counts stalled cycles of one bus transaction and
// flags expiry on the MAX_WAIT-th consecutive stall cycle.
module mu0_wait_timer #(
   parameter int MAX_WAIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic cnt_en_i,
   output logic expired_o
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   // Expiry is the stall cycle that would make the count reach MAX_WAIT.
   assign expired_o = cnt_en_i && (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (clear_i)
         wait_cnt_d = '0;
      else if (cnt_en_i && !expired_o)
         wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) wait_cnt_q <= '0;
      else     wait_cnt_q <= wait_cnt_d;
   end
endmodule

// File: rtl/mu0_shared_mem_sequencer.sv
// MU0 memory-access sequencer: fetch, optional data read/write, then a
// one-cycle valid_read strobe to the core. Sticky bus error on timeout.
module mu0_shared_mem_sequencer
   import mu0_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_WAIT   = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  running,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] writedata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  valid_read,
   output logic                  bus_error,
   mu0_shared_mem_sequencer_if.master mem
);
   seq_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
   logic                  on_bus;
   logic                  expired;
   opcode_t               fetch_op;

   assign fetch_op = opcode_t'(mem.mem_readdata[DATA_WIDTH-1 -: OPCODE_W]);
   assign on_bus   = (state_q == S_FETCH) || (state_q == S_DATA_RD) || (state_q == S_DATA_WR);

   // Any state change is an entry into a new transaction (or leaves the bus).
   mu0_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (state_d != state_q),
      .cnt_en_i  (on_bus && mem.mem_waitrequest),
      .expired_o (expired)
   );

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      readdata_d = readdata_q;
      case (state_q)
         S_IDLE:
            if (running) state_d = S_FETCH;
         S_FETCH:
            if (!mem.mem_waitrequest) begin
               instr_d = mem.mem_readdata;
               if (opcode_needs_read(fetch_op))       state_d = S_DATA_RD;
               else if (opcode_needs_write(fetch_op)) state_d = S_DATA_WR;
               else                                   state_d = S_EXEC;
            end else if (expired) begin
               state_d = S_ERROR;
            end
         S_DATA_RD:
            if (!mem.mem_waitrequest) begin
               readdata_d = mem.mem_readdata;
               state_d    = S_EXEC;
            end else if (expired) begin
               state_d = S_ERROR;
            end
         S_DATA_WR:
            if (!mem.mem_waitrequest) state_d = S_EXEC;
            else if (expired)         state_d = S_ERROR;
         S_EXEC:  state_d = S_IDLE;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
   end

   // Bus controls decode from registered state only, so they hold across stalls.
   always_comb begin
      mem.mem_read      = 1'b0;
      mem.mem_write     = 1'b0;
      mem.mem_address   = '0;
      mem.mem_writedata = '0;
      valid_read        = 1'b0;
      bus_error         = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem.mem_read    = 1'b1;
            mem.mem_address = pc;
         end
         S_DATA_RD: begin
            mem.mem_read    = 1'b1;
            mem.mem_address = ADDR_WIDTH'(instr_q[IMM_W-1:0]);
         end
         S_DATA_WR: begin
            mem.mem_write     = 1'b1;
            mem.mem_address   = ADDR_WIDTH'(instr_q[IMM_W-1:0]);
            mem.mem_writedata = writedata;
         end
         S_EXEC:  valid_read = 1'b1;
         S_ERROR: bus_error  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         instr_q    <= '0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         readdata_q <= readdata_d;
      end
   end

   assign instr    = instr_q;
   assign readdata = readdata_q;
endmodule

// File: tb/tb_mu0_shared_mem_sequencer.sv
// Directed bench for the MU0 memory sequencer with a stallable memory model.
module tb_mu0_shared_mem_sequencer;
   import mu0_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        running = 1'b0;
   logic [11:0] pc = '0;
   logic [15:0] writedata = '0;
   logic [15:0] instr, readdata;
   logic        valid_read, bus_error;
   logic        wait_r = 1'b0;

   logic [15:0] rom [0:4095];
   int          rd_cnt = 0, wr_cnt = 0, vr_cnt = 0;
   logic [11:0] last_wr_addr = '0;
   logic [15:0] last_wr_data = '0;
   int          n_checks = 0, n_fail = 0;
   int          rd0, wr0, vr0;

   always #5 clk = ~clk;

   mu0_shared_mem_sequencer_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) mif ();

   assign mif.mem_readdata    = rom[mif.mem_address];
   assign mif.mem_waitrequest = wait_r;

   mu0_shared_mem_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .MAX_WAIT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .running    (running),
      .pc         (pc),
      .writedata  (writedata),
      .instr      (instr),
      .readdata   (readdata),
      .valid_read (valid_read),
      .bus_error  (bus_error),
      .mem        (mif.master)
   );

   // Memory-side bookkeeping of accepted transfers and strobes.
   always @(posedge clk) begin
      if (mif.mem_read && !mif.mem_waitrequest) rd_cnt <= rd_cnt + 1;
      if (mif.mem_write && !mif.mem_waitrequest) begin
         wr_cnt       <= wr_cnt + 1;
         last_wr_addr <= mif.mem_address;
         last_wr_data <= mif.mem_writedata;
      end
      if (valid_read) vr_cnt <= vr_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; running = 1'b0; wait_r = 1'b0;
      step(); step();
      rst = 1'b0;
      n_checks++; if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, S_IDLE); end
      n_checks++; if ({mif.mem_read, mif.mem_write, valid_read, bus_error} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {mif.mem_read, mif.mem_write, valid_read, bus_error}); end
      n_checks++; if ({mif.mem_address, mif.mem_writedata, instr, readdata} !== 60'h0) begin n_fail++; $display("FAIL reset_data: got addr %h wd %h instr %h rd %h want 0", mif.mem_address, mif.mem_writedata, instr, readdata); end
      step();
      n_checks++; if (mif.mem_read !== 1'b0) begin n_fail++; $display("FAIL idle_no_read: got %b want 0", mif.mem_read); end
   endtask

   task automatic test_lda();
      rom[0] = 16'h0005; rom[5] = 16'h1234; pc = 12'd0;
      running = 1'b1;
      step();
      n_checks++; if (mif.mem_read !== 1'b1 || mif.mem_address !== 12'd0) begin n_fail++; $display("FAIL lda_fetch: got rd %b addr %h want 1 000", mif.mem_read, mif.mem_address); end
      step();
      n_checks++; if (mif.mem_read !== 1'b1 || mif.mem_address !== 12'd5) begin n_fail++; $display("FAIL lda_data_rd: got rd %b addr %h want 1 005", mif.mem_read, mif.mem_address); end
      n_checks++; if (valid_read !== 1'b0) begin n_fail++; $display("FAIL lda_early_valid: got %b want 0", valid_read); end
      step();
      running = 1'b0;
      n_checks++; if (valid_read !== 1'b1 || instr !== 16'h0005 || readdata !== 16'h1234) begin n_fail++; $display("FAIL lda_exec: got v %b instr %h rd %h want 1 0005 1234", valid_read, instr, readdata); end
      step();
      n_checks++; if (valid_read !== 1'b0 || dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL lda_strobe_len: got v %b state %0d want 0 IDLE", valid_read, dut.state_q); end
   endtask

   task automatic test_sto();
      rom[1] = 16'h1006; rom[6] = 16'h0000; pc = 12'd1; writedata = 16'h00AB;
      rd0 = rd_cnt; wr0 = wr_cnt;
      running = 1'b1;
      step();
      n_checks++; if (mif.mem_writedata !== 16'h0) begin n_fail++; $display("FAIL sto_wd_outside: got %h want 0000", mif.mem_writedata); end
      step();
      n_checks++; if (mif.mem_write !== 1'b1 || mif.mem_read !== 1'b0 || mif.mem_address !== 12'd6 || mif.mem_writedata !== 16'h00AB) begin n_fail++; $display("FAIL sto_write: got wr %b rd %b addr %h wd %h want 1 0 006 00ab", mif.mem_write, mif.mem_read, mif.mem_address, mif.mem_writedata); end
      step();
      running = 1'b0;
      n_checks++; if (valid_read !== 1'b1 || mif.mem_write !== 1'b0 || readdata !== 16'h1234) begin n_fail++; $display("FAIL sto_exec: got v %b wr %b rd %h want 1 0 1234", valid_read, mif.mem_write, readdata); end
      n_checks++; if (wr_cnt - wr0 !== 1 || last_wr_addr !== 12'd6 || last_wr_data !== 16'h00AB || rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL sto_counts: got wr %0d @%h=%h reads %0d want 1 @006=00ab 1", wr_cnt - wr0, last_wr_addr, last_wr_data, rd_cnt - rd0); end
      step();
   endtask

   task automatic test_jmp();
      rom[3] = 16'h4010; pc = 12'd3; rd0 = rd_cnt;
      running = 1'b1;
      step();
      step();
      running = 1'b0;
      n_checks++; if (valid_read !== 1'b1 || instr !== 16'h4010 || readdata !== 16'h1234 || mif.mem_read !== 1'b0) begin n_fail++; $display("FAIL jmp_exec: got v %b instr %h rd %h mrd %b want 1 4010 1234 0", valid_read, instr, readdata, mif.mem_read); end
      n_checks++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL jmp_reads: got %0d want 1", rd_cnt - rd0); end
      step();
   endtask

   task automatic test_fetch_stall();
      rom[2] = 16'h5020; pc = 12'd2; wait_r = 1'b1;
      running = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) wait_r = 1'b0;
         n_checks++; if (mif.mem_read !== 1'b1 || mif.mem_address !== 12'd2 || instr !== 16'h4010) begin n_fail++; $display("FAIL stall_hold%0d: got rd %b addr %h instr %h want 1 002 4010", i, mif.mem_read, mif.mem_address, instr); end
         step();
      end
      running = 1'b0;
      n_checks++; if (valid_read !== 1'b1 || instr !== 16'h5020 || bus_error !== 1'b0) begin n_fail++; $display("FAIL stall_exec: got v %b instr %h err %b want 1 5020 0", valid_read, instr, bus_error); end
      step();
   endtask

   task automatic test_sub_and_high_opcode();
      rom[10] = 16'h300C; rom[12] = 16'hBEEF; rom[11] = 16'hF123; pc = 12'd10;
      running = 1'b1;
      step(); step();
      n_checks++; if (mif.mem_read !== 1'b1 || mif.mem_address !== 12'd12) begin n_fail++; $display("FAIL sub_data_rd: got rd %b addr %h want 1 00c", mif.mem_read, mif.mem_address); end
      step();
      n_checks++; if (valid_read !== 1'b1 || readdata !== 16'hBEEF) begin n_fail++; $display("FAIL sub_exec: got v %b rd %h want 1 beef", valid_read, readdata); end
      pc = 12'd11;
      step(); step(); step();
      running = 1'b0;
      n_checks++; if (valid_read !== 1'b1 || instr !== 16'hF123 || readdata !== 16'hBEEF) begin n_fail++; $display("FAIL opF_exec: got v %b instr %h rd %h want 1 f123 beef", valid_read, instr, readdata); end
      step();
   endtask

   task automatic test_timeout();
      rom[4] = 16'h2007; pc = 12'd4; vr0 = vr_cnt;
      wait_r = 1'b1; running = 1'b1;
      step(); step(); step();
      wait_r = 1'b0;
      step();
      wait_r = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (mif.mem_read !== 1'b1 || mif.mem_address !== 12'd7 || bus_error !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: got rd %b addr %h err %b want 1 007 0", i, mif.mem_read, mif.mem_address, bus_error); end
         step();
      end
      step();
      n_checks++; if (bus_error !== 1'b1 || mif.mem_read !== 1'b0 || mif.mem_write !== 1'b0 || valid_read !== 1'b0) begin n_fail++; $display("FAIL to_error: got err %b rd %b wr %b v %b want 1 0 0 0", bus_error, mif.mem_read, mif.mem_write, valid_read); end
      wait_r = 1'b0;
      step(); step();
      n_checks++; if (bus_error !== 1'b1 || vr_cnt !== vr0) begin n_fail++; $display("FAIL to_sticky: got err %b strobes %0d want 1 0", bus_error, vr_cnt - vr0); end
      rst = 1'b1; running = 1'b0;
      step();
      rst = 1'b0;
      n_checks++; if ({bus_error, mif.mem_read, mif.mem_write, valid_read} !== 4'b0 || mif.mem_address !== 12'd0 || dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL to_reset: got err %b rd %b wr %b v %b addr %h want all 0", bus_error, mif.mem_read, mif.mem_write, valid_read, mif.mem_address); end
   endtask

   task automatic test_stp_and_mid_reset();
      rom[8] = 16'h7000; rom[9] = 16'h0005; pc = 12'd8;
      running = 1'b1;
      step(); step();
      running = 1'b0;
      n_checks++; if (valid_read !== 1'b1 || instr !== 16'h7000) begin n_fail++; $display("FAIL stp_exec: got v %b instr %h want 1 7000", valid_read, instr); end
      rd0 = rd_cnt;
      step(); step(); step();
      n_checks++; if (dut.state_q !== S_IDLE || mif.mem_read !== 1'b0 || rd_cnt !== rd0) begin n_fail++; $display("FAIL stp_halt: got state %0d rd %b reads %0d want IDLE 0 0", dut.state_q, mif.mem_read, rd_cnt - rd0); end
      pc = 12'd9; running = 1'b1;
      step(); step();
      wait_r = 1'b1;
      n_checks++; if (mif.mem_read !== 1'b1 || dut.state_q !== S_DATA_RD) begin n_fail++; $display("FAIL mid_pre: got rd %b state %0d want 1 DATA_RD", mif.mem_read, dut.state_q); end
      rst = 1'b1; running = 1'b0;
      step();
      rst = 1'b0; wait_r = 1'b0;
      n_checks++; if (mif.mem_read !== 1'b0 || dut.state_q !== S_IDLE || instr !== 16'h0) begin n_fail++; $display("FAIL mid_reset: got rd %b state %0d instr %h want 0 IDLE 0000", mif.mem_read, dut.state_q, instr); end
      step();
      n_checks++; if (dut.state_q !== S_IDLE || mif.mem_read !== 1'b0) begin n_fail++; $display("FAIL mid_after: got state %0d rd %b want IDLE 0", dut.state_q, mif.mem_read); end
   endtask

   initial begin
      for (int a = 0; a < 4096; a++) rom[a] = 16'h0;
      test_reset();
      test_lda();
      test_sto();
      test_jmp();
      test_fetch_stall();
      test_sub_and_high_opcode();
      test_timeout();
      test_stp_and_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
